// File: rtl/serial_logic_unit_if.sv
// Operand/result bundle between the decode stage, the serial logic unit and writeback.
// The master side issues operations; the slave side is the logic unit itself.
interface serial_logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (output start, op, a, b, input busy, done, result, zero);
  modport slave  (input start, op, a, b, output busy, done, result, zero);
endinterface

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit: one operand bit per clock through a gate-level cell,
// LSB first, with a registered result, a one-cycle done pulse and a zero flag.
module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_logic_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             load;
  logic             f;

  // Single-bit logic cell: every candidate function from primitives, opcode picks one.
  wire g_and, g_or, g_nand, g_nor, g_xor, g_xnor, g_nota;

  and  u_and  (g_and,  sa[0], sb[0]);
  or   u_or   (g_or,   sa[0], sb[0]);
  nand u_nand (g_nand, sa[0], sb[0]);
  nor  u_nor  (g_nor,  sa[0], sb[0]);
  xor  u_xor  (g_xor,  sa[0], sb[0]);
  xnor u_xnor (g_xnor, sa[0], sb[0]);
  not  u_nota (g_nota, sa[0]);

  always_comb begin
    // NOTE: default first so no path leaves f unassigned, which would infer a latch.
    f = 1'b0;
    case (op_q)
      3'b000: f = g_and;
      3'b001: f = g_or;
      3'b010: f = g_nand;
      3'b011: f = g_nor;
      3'b100: f = g_xor;
      3'b101: f = g_xnor;
      3'b110: f = g_nota;
      3'b111: f = sb[0];
      default: f = 1'b0;
    endcase
  end

  assign acc_next = {f, acc[WIDTH-1:1]};
  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  // Start is only honoured when not shifting; DONE accepts it for back-to-back issue.
  assign load     = bus.start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = bus.start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      SHIFT:   bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      op_q       <= '0;
      acc        <= '0;
      cnt        <= '0;
      bus.result <= '0;
      bus.zero   <= 1'b1;
    end else if (load) begin
      sa   <= bus.a;
      sb   <= bus.b;
      op_q <= bus.op;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      acc <= acc_next;
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      cnt <= cnt + 1'b1;
      // Result is published only on the final bit so writeback never sees a partial word.
      if (last_bit) begin
        bus.result <= acc_next;
        bus.zero   <= (acc_next == '0);
      end
    end
  end
endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit: directed vector table, multi-cycle corner
// sequences, and random operations checked against a word-level reference model.
module tb_serial_logic_unit;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_logic_unit_if #(.WIDTH(WIDTH)) bus ();
  serial_logic_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction

  // Drives a one-cycle start and returns just after the capture edge, scrambling inputs.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
  endtask

  // Counts edges until done, noting whether busy held and result stayed stable meanwhile.
  task automatic wait_done(output int lat, output logic busy_ok, output logic hold_ok);
    logic [WIDTH-1:0] prev;
    prev    = bus.result;
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 4 * WIDTH) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.result !== prev) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    int   lat;
    logic busy_ok, hold_ok;
    issue(op, a, b);
    wait_done(lat, busy_ok, hold_ok);
    check({name, " latency"}, lat, WIDTH);
    check({name, " busy"}, busy_ok, 1'b1);
    check({name, " hold"}, hold_ok, 1'b1);
    check({name, " result"}, bus.result, exp);
    check({name, " zero"}, bus.zero, (exp == '0));
    check({name, " busy at done"}, bus.busy, 1'b0);
    @(posedge clk); #1;
    check({name, " done pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int   lat, lat2, cyc, pulses;
    logic busy_ok, hold_ok;

    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0] = '{3'b001, 8'hF0, 8'hCC, 8'hFC};
    vecs[1] = '{3'b000, 8'hF0, 8'hCC, 8'hC0};
    vecs[2] = '{3'b010, 8'hF0, 8'hCC, 8'h3F};
    vecs[3] = '{3'b011, 8'hF0, 8'hCC, 8'h03};
    vecs[4] = '{3'b100, 8'h5A, 8'h5A, 8'h00};
    vecs[5] = '{3'b101, 8'hF0, 8'hCC, 8'hC3};
    vecs[6] = '{3'b110, 8'h0F, 8'h33, 8'hF0};
    vecs[7] = '{3'b111, 8'h12, 8'hA5, 8'hA5};
    vecs[8] = '{3'b000, 8'h0F, 8'hF0, 8'h00};
    vecs[9] = '{3'b110, 8'hFF, 8'h00, 8'h00};

    // Reset state, asserted before any clock edge
    #2 rst = 1'b1;
    #1;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset result", bus.result, 8'h00);
    check("reset zero", bus.zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Back-to-back: NAND, then PASS B issued in the done cycle
    issue(3'b010, 8'hF0, 8'hCC);
    wait_done(lat, busy_ok, hold_ok);
    check("b2b first latency", lat, WIDTH);
    check("b2b first result", bus.result, 8'h3F);
    bus.start = 1'b1;
    bus.op    = 3'b111;
    bus.a     = 8'h00;
    bus.b     = 8'hA5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.b     = 8'h00;
    check("b2b recapture busy", bus.busy, 1'b1);
    wait_done(lat2, busy_ok, hold_ok);
    check("b2b spacing", lat2 + 1, WIDTH + 1);
    check("b2b busy", busy_ok, 1'b1);
    check("b2b second result", bus.result, 8'hA5);
    check("b2b second zero", bus.zero, 1'b0);
    @(posedge clk); #1;

    // Start while busy is ignored
    issue(3'b000, 8'hFF, 8'h0F);
    cyc = 0;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    bus.start = 1'b1;
    bus.a     = 8'h00;
    bus.op    = 3'b011;
    @(posedge clk); #1;
    cyc++;
    bus.start = 1'b0;
    wait_done(lat, busy_ok, hold_ok);
    check("busy-start latency", cyc + lat, WIDTH);
    check("busy-start result", bus.result, 8'h0F);
    pulses = 0;
    repeat (2 * WIDTH) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("busy-start extra done", pulses, 0);

    // Reset mid-operation
    issue(3'b110, 8'h0F, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", bus.busy, 1'b0);
    check("midrst done", bus.done, 1'b0);
    check("midrst result", bus.result, 8'h00);
    check("midrst zero", bus.zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (2 * WIDTH) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("midrst no done", pulses, 0);
    run_op("after reset", 3'b110, 8'h0F, 8'h00, 8'hF0);

    // Random operations against the word-level model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]       op;
      logic [WIDTH-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
      if (i % 8 == 0) b = a;
      run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
